// File: rtl/video_sync_h_gen_pkg.sv
// Purpose: shared timing constants and display-mode encoding for the horizontal generator.
// Latency: n/a (constants only).
// Backpressure: n/a.
package video_timing_pkg;

    // Default counter / pixel column width
    localparam int DEF_CW         = 9;

    // Line geometry, in cend ticks
    localparam int DEF_HPERIOD    = 448;
    localparam int DEF_HSYNC_BEG  = 10;
    localparam int DEF_HSYNC_END  = 43;
    localparam int DEF_HBLNK_END  = 88;
    localparam int DEF_SCANIN_BEG = 88;
    localparam int DEF_HINT_BEG   = 443;

    // Pixel window per display mode; BEG==END means the window never opens
    localparam int DEF_HPIX_BEG_M0 = 140;
    localparam int DEF_HPIX_END_M0 = 396;
    localparam int DEF_HPIX_BEG_M1 = 108;
    localparam int DEF_HPIX_END_M1 = 428;
    localparam int DEF_HPIX_BEG_M2 = 92;
    localparam int DEF_HPIX_END_M2 = 444;
    localparam int DEF_HPIX_BEG_M3 = 0;
    localparam int DEF_HPIX_END_M3 = 0;

    // Display mode encoding
    localparam logic [1:0] MODE_PENT   = 2'd0;
    localparam logic [1:0] MODE_ATM    = 2'd1;
    localparam logic [1:0] MODE_W352   = 2'd2;
    localparam logic [1:0] MODE_BORDER = 2'd3;

endpackage

// File: rtl/video_sync_h_gen_if.sv
// Purpose: bundle of timing enables, mode request and generated horizontal timing signals.
// Latency: n/a (wires only).
// Backpressure: none; all signals are free-running strobes/levels.
// master = the generator, slave = the enable source / timing consumer.
interface video_sync_h_gen_if #(
    parameter int CW = video_timing_pkg::DEF_CW
);
    logic          cend;
    logic          pre_cend;
    logic          init;
    logic [1:0]    mode;
    logic [1:0]    mode_cur;
    logic          hblank;
    logic          hsync;
    logic          line_start;
    logic          hsync_start;
    logic          scanin_start;
    logic          hint_start;
    logic          hpix;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] hcount;

    modport master (
        input  cend, pre_cend, init, mode,
        output mode_cur, hblank, hsync, line_start, hsync_start,
               scanin_start, hint_start, hpix, pix_x, hcount
    );

    modport slave (
        output cend, pre_cend, init, mode,
        input  mode_cur, hblank, hsync, line_start, hsync_start,
               scanin_start, hint_start, hpix, pix_x, hcount
    );

endinterface

// File: rtl/video_sync_h_gen_hwindow.sv
// Purpose: set/reset window flop; opens when pos==win_beg, closes when pos==win_end.
// Latency: 1 clk from the enabled edge that sees the matching pos.
// Backpressure: none; state only moves when en=1.
// Ports: clk/rst (sync, active high), en (tick enable), clr (forced close with en),
//        pos (current position), win_beg/win_end (window edges), win (window level).
module video_hwindow #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [CW-1:0] pos,
    input  logic [CW-1:0] win_beg,
    input  logic [CW-1:0] win_end,
    output logic          win
);

    always_ff @(posedge clk) begin
        if (rst) begin
            win <= 1'b0;
        end else if (en) begin
            if (clr) begin
                win <= 1'b0;
            end else if (pos == win_beg && win_beg != win_end) begin
                // Equal edges describe an empty window, so it must never open
                win <= 1'b1;
            end else if (pos == win_end) begin
                win <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/video_sync_h_gen.sv
// Purpose: horizontal line timer: counter, mode latch, blank/sync/pixel windows and strobes.
// Latency: levels follow the pre-edge hcount by 1 clk; strobes land on the cend after pre_cend.
// Backpressure: none; advances only on cend, holds otherwise.
// Ports: clk, rst (sync, active high); bus (master) carries cend/pre_cend/init/mode in
//        and mode_cur, hblank, hsync, four strobes, hpix, pix_x, hcount out.
module video_sync_h_gen
    import video_timing_pkg::*;
#(
    parameter int CW          = DEF_CW,
    parameter int HPERIOD     = DEF_HPERIOD,
    parameter int HSYNC_BEG   = DEF_HSYNC_BEG,
    parameter int HSYNC_END   = DEF_HSYNC_END,
    parameter int HBLNK_END   = DEF_HBLNK_END,
    parameter int SCANIN_BEG  = DEF_SCANIN_BEG,
    parameter int HINT_BEG    = DEF_HINT_BEG,
    parameter int HPIX_BEG_M0 = DEF_HPIX_BEG_M0,
    parameter int HPIX_END_M0 = DEF_HPIX_END_M0,
    parameter int HPIX_BEG_M1 = DEF_HPIX_BEG_M1,
    parameter int HPIX_END_M1 = DEF_HPIX_END_M1,
    parameter int HPIX_BEG_M2 = DEF_HPIX_BEG_M2,
    parameter int HPIX_END_M2 = DEF_HPIX_END_M2,
    parameter int HPIX_BEG_M3 = DEF_HPIX_BEG_M3,
    parameter int HPIX_END_M3 = DEF_HPIX_END_M3
) (
    input  logic               clk,
    input  logic               rst,
    video_sync_h_gen_if.master bus
);

    localparam logic [CW-1:0] C_LAST       = CW'(HPERIOD - 1);
    localparam logic [CW-1:0] C_ZERO       = '0;
    localparam logic [CW-1:0] C_HSYNC_BEG  = CW'(HSYNC_BEG);
    localparam logic [CW-1:0] C_HSYNC_END  = CW'(HSYNC_END);
    localparam logic [CW-1:0] C_HBLNK_END  = CW'(HBLNK_END);
    localparam logic [CW-1:0] C_SCANIN_BEG = CW'(SCANIN_BEG);
    localparam logic [CW-1:0] C_HINT_BEG   = CW'(HINT_BEG);

    logic [CW-1:0] hcount;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] hpix_beg;
    logic [CW-1:0] hpix_end;
    logic [1:0]    mode_cur;
    logic          hblank;
    logic          hsync;
    logic          hpix;
    logic          line_start;
    logic          hsync_start;
    logic          scanin_start;
    logic          hint_start;
    logic          line_wrap;
    logic          pix_start;

    // Pixel window edges for the mode latched at the start of this line
    always_comb begin
        hpix_beg = CW'(HPIX_BEG_M3);
        hpix_end = CW'(HPIX_END_M3);
        case (mode_cur)
            MODE_PENT: begin
                hpix_beg = CW'(HPIX_BEG_M0);
                hpix_end = CW'(HPIX_END_M0);
            end
            MODE_ATM: begin
                hpix_beg = CW'(HPIX_BEG_M1);
                hpix_end = CW'(HPIX_END_M1);
            end
            MODE_W352: begin
                hpix_beg = CW'(HPIX_BEG_M2);
                hpix_end = CW'(HPIX_END_M2);
            end
            default: begin
                hpix_beg = CW'(HPIX_BEG_M3);
                hpix_end = CW'(HPIX_END_M3);
            end
        endcase
    end

    // init and natural wrap both restart the line and re-latch the mode
    assign line_wrap = bus.init || (hcount == C_LAST);
    assign pix_start = (hcount == hpix_beg) && (hpix_beg != hpix_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount       <= '0;
            mode_cur     <= bus.mode;
            pix_x        <= '0;
            line_start   <= 1'b0;
            hsync_start  <= 1'b0;
            scanin_start <= 1'b0;
            hint_start   <= 1'b0;
        end else begin
            // Strobes are decoded one clk early so they sit on top of the next cend
            line_start   <= bus.pre_cend && (hcount == C_HBLNK_END);
            hsync_start  <= bus.pre_cend && (hcount == C_HSYNC_BEG);
            scanin_start <= bus.pre_cend && (hcount == C_SCANIN_BEG);
            hint_start   <= bus.pre_cend && (hcount == C_HINT_BEG);
            if (bus.cend) begin
                if (line_wrap) begin
                    hcount   <= '0;
                    mode_cur <= bus.mode;
                end else begin
                    hcount <= hcount + CW'(1);
                end
                // Closing edge does not count, so pix_x stops at END-BEG-1
                if (bus.init && hpix) begin
                    pix_x <= '0;
                end else if (pix_start) begin
                    pix_x <= '0;
                end else if (hpix && hcount != hpix_end) begin
                    pix_x <= pix_x + CW'(1);
                end
            end
        end
    end

    video_hwindow #(.CW(CW)) u_hblank (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.cend),
        .clr     (1'b0),
        .pos     (hcount),
        .win_beg (C_ZERO),
        .win_end (C_HBLNK_END),
        .win     (hblank)
    );

    video_hwindow #(.CW(CW)) u_hsync (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.cend),
        .clr     (1'b0),
        .pos     (hcount),
        .win_beg (C_HSYNC_BEG),
        .win_end (C_HSYNC_END),
        .win     (hsync)
    );

    // A phase restart drops any open pixel window instead of carrying it over
    video_hwindow #(.CW(CW)) u_hpix (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.cend),
        .clr     (bus.init),
        .pos     (hcount),
        .win_beg (hpix_beg),
        .win_end (hpix_end),
        .win     (hpix)
    );

    assign bus.hcount       = hcount;
    assign bus.mode_cur     = mode_cur;
    assign bus.pix_x        = pix_x;
    assign bus.hblank       = hblank;
    assign bus.hsync        = hsync;
    assign bus.hpix         = hpix;
    assign bus.line_start   = line_start;
    assign bus.hsync_start  = hsync_start;
    assign bus.scanin_start = scanin_start;
    assign bus.hint_start   = hint_start;

endmodule

// File: tb/tb_video_sync_h_gen.sv
// Purpose: randomized enable/mode/init stimulus against a line-position reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_video_sync_h_gen;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    video_sync_h_gen_if #(.CW(9)) bus ();

    video_sync_h_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference pixel windows per mode, straight from the timing table
    function automatic int pix_beg(input int m);
        case (m)
            0:       return 140;
            1:       return 108;
            2:       return 92;
            default: return 0;
        endcase
    endfunction

    function automatic int pix_end(input int m);
        case (m)
            0:       return 396;
            1:       return 428;
            2:       return 444;
            default: return 0;
        endcase
    endfunction

    // Pixel window is visible for hcount in (BEG, END]
    function automatic bit in_win(input int hc, input int m);
        return (pix_beg(m) != pix_end(m)) && (hc > pix_beg(m)) && (hc <= pix_end(m));
    endfunction

    // Stimulus state
    int   cnt      = 1;
    int   mode_in  = 0;
    bit   init_req = 1'b0;
    bit   rst_in   = 1'b1;

    // Reference model state
    bit   m_valid = 1'b0;
    int   m_hc    = 0;
    int   m_mode  = 0;
    int   m_px    = 0;
    bit   p_prev  = 1'b0;
    bit   r_prev  = 1'b1;

    // Per-line statistics collected from DUT outputs
    int   st_ticks, st_hs, st_hb, st_hp, st_last, st_ls, st_hi;
    int   last_tick_hc = -1;

    task automatic clear_stats();
        st_ticks = 0; st_hs = 0; st_hb = 0; st_hp = 0;
        st_last = -1; st_ls = 0; st_hi = 0;
    endtask

    // One clock: drive at posedge+1, check at posedge+2, advance model after the edge
    task automatic cyc();
        bit c, p, i, armed, was_win;
        c = (cnt == 0);
        p = (cnt == 1);
        cnt = c ? int'($urandom_range(3, 1)) : cnt - 1;
        if (rst_in) init_req = 1'b0;
        if (c) i = init_req;
        else   i = ($urandom_range(7, 0) == 0);   // init without cend must be ignored
        bus.cend     = c;
        bus.pre_cend = p;
        bus.init     = i;
        bus.mode     = 2'(mode_in);
        rst          = rst_in;
        #1;
        last_tick_hc = -1;
        if (m_valid) begin
            chk("hcount",   int'(bus.hcount),   m_hc);
            chk("hblank",   int'(bus.hblank),   int'(m_hc >= 1 && m_hc <= 88));
            chk("hsync",    int'(bus.hsync),    int'(m_hc >= 11 && m_hc <= 43));
            chk("hpix",     int'(bus.hpix),     int'(in_win(m_hc, m_mode)));
            chk("pix_x",    int'(bus.pix_x),    m_px);
            chk("mode_cur", int'(bus.mode_cur), m_mode);
            armed = c && p_prev && !r_prev;
            chk("line_start",   int'(bus.line_start),   int'(armed && m_hc == 88));
            chk("hsync_start",  int'(bus.hsync_start),  int'(armed && m_hc == 10));
            chk("scanin_start", int'(bus.scanin_start), int'(armed && m_hc == 88));
            chk("hint_start",   int'(bus.hint_start),   int'(armed && m_hc == 443));
            if (c && !rst_in) begin
                last_tick_hc = int'(bus.hcount);
                st_ticks++;
                st_hs += int'(bus.hsync);
                st_hb += int'(bus.hblank);
                st_hp += int'(bus.hpix);
                if (bus.hpix) st_last = int'(bus.pix_x);
                if (bus.line_start && bus.hcount == 9'd88) st_ls++;
                if (bus.hint_start && bus.hcount == 9'd443) st_hi++;
            end
        end
        @(posedge clk);
        #1;
        p_prev = p;
        r_prev = rst_in;
        if (rst_in) begin
            m_hc    = 0;
            m_mode  = mode_in;
            m_px    = 0;
            m_valid = 1'b1;
        end else if (c) begin
            was_win = in_win(m_hc, m_mode);
            if (i || m_hc == 447) begin
                m_hc   = 0;
                m_mode = mode_in;
                if (i && was_win) m_px = 0;
            end else begin
                m_hc++;
            end
            if (in_win(m_hc, m_mode)) m_px = m_hc - pix_beg(m_mode) - 1;
            if (i) init_req = 1'b0;
        end
    endtask

    // Run until the cend tick seen at hcount==target (bounded)
    task automatic run_to(input int target);
        int guard = 0;
        do begin
            cyc();
            guard++;
        end while (last_tick_hc != target && guard < 4000);
        chk("reach_hc", last_tick_hc, target);
    endtask

    initial begin
        clear_stats();
        bus.cend = 1'b0; bus.pre_cend = 1'b0; bus.init = 1'b0; bus.mode = 2'd0;
        rst = 1'b1;
        #1;

        // Reset and free-run in mode 0
        rst_in = 1'b1; mode_in = 0;
        repeat (3) cyc();
        rst_in = 1'b0;
        run_to(0);
        clear_stats();
        run_to(0);
        chk("m0_period",  st_ticks, 448);
        chk("m0_hsync",   st_hs,    33);
        chk("m0_hblank",  st_hb,    88);
        chk("m0_hpix",    st_hp,    256);
        chk("m0_last_px", st_last,  255);

        // Mode 1 held
        mode_in = 1;
        run_to(0);
        clear_stats();
        run_to(0);
        chk("m1_hpix",       st_hp,   320);
        chk("m1_last_px",    st_last, 319);
        chk("m1_line_start", st_ls,   1);
        chk("m1_hint_start", st_hi,   1);

        // Switch 0 -> 1 mid-line: current line keeps the mode-0 window
        mode_in = 0;
        run_to(0);
        run_to(0);
        clear_stats();
        run_to(200);
        mode_in = 1;
        run_to(0);
        chk("sw_old_hpix", st_hp, 256);
        clear_stats();
        run_to(0);
        chk("sw_new_hpix", st_hp, 320);

        // Border-only mode
        mode_in = 3;
        run_to(0);
        clear_stats();
        run_to(0);
        chk("m3_hpix",   st_hp, 0);
        chk("m3_hsync",  st_hs, 33);
        chk("m3_hblank", st_hb, 88);

        // init inside the mode-0 window
        mode_in = 0;
        run_to(0);
        run_to(250);
        init_req = 1'b1;
        run_to(0);
        chk("init_hpix",  int'(bus.hpix),  0);
        chk("init_pix_x", int'(bus.pix_x), 0);
        clear_stats();
        run_to(0);
        chk("init_period", st_ticks, 448);
        chk("init_hpix_w", st_hp,    256);

        // Reset mid-window
        mode_in = 1;
        run_to(0);
        run_to(300);
        rst_in = 1'b1; mode_in = 2;
        cyc();
        rst_in = 1'b0;
        chk("rst_hcount",   int'(bus.hcount),       0);
        chk("rst_hpix",     int'(bus.hpix),         0);
        chk("rst_pix_x",    int'(bus.pix_x),        0);
        chk("rst_hblank",   int'(bus.hblank),       0);
        chk("rst_hsync",    int'(bus.hsync),        0);
        chk("rst_strobes",  int'({bus.line_start, bus.hsync_start,
                                  bus.scanin_start, bus.hint_start}), 0);
        chk("rst_mode_cur", int'(bus.mode_cur),     2);
        run_to(0);

        // Random mode changes, phase restarts and occasional resets
        for (int n = 0; n < 12000; n++) begin
            if ($urandom_range(599, 0) == 0) mode_in = int'($urandom_range(3, 0));
            if (!init_req && m_hc >= 100 && m_hc <= 440 && $urandom_range(1499, 0) == 0)
                init_req = 1'b1;
            rst_in = ($urandom_range(4999, 0) == 0);
            cyc();
        end
        rst_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_sync_h_gen.md
Name: video_sync_h_gen

Overview:
- Parametrised horizontal timing generator; next generation of the fixed 448-clock Pentagon/ATM line timer.
- Runs on the 7 MHz cend/pre_cend enables from the DRAM controller.
- Generates hblank, hsync, scan-doubler and INT strobes, and a per-mode pixel window with a pixel column counter.
- Supports four selectable display modes. Mode changes take effect only at a line boundary, so a line can never tear.

Parameters:
CW, 9, width of hcount and pix_x
HPERIOD, 448, line length in cend ticks; counter wraps at HPERIOD-1
HSYNC_BEG, 10, hcount at which hsync rises
HSYNC_END, 43, hcount at which hsync falls
HBLNK_END, 88, hcount at which hblank falls; also the line_start position
SCANIN_BEG, 88, hcount of the scanin_start strobe
HINT_BEG, 443, hcount of the hint_start strobe
HPIX_BEG_M0 / HPIX_END_M0, 140 / 396, mode 0: Pentagon, 256 pixels
HPIX_BEG_M1 / HPIX_END_M1, 108 / 428, mode 1: ATM, 320 pixels
HPIX_BEG_M2 / HPIX_END_M2, 92 / 444, mode 2: 352 pixels
HPIX_BEG_M3 / HPIX_END_M3, 0 / 0, mode 3: border only; window never opens

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cend  in  1  7 MHz working strobe
pre_cend  in  1  strobe one clk before cend
init  in  1  phase-init request, sampled only with cend
mode  in  2  requested display mode
mode_cur  out  2  mode in effect for the current line
hblank  out  1  horizontal blank
hsync  out  1  horizontal sync, active high
line_start  out  1  one-clk strobe, coincides with cend at hcount==HBLNK_END
hsync_start  out  1  one-clk strobe, coincides with cend at hcount==HSYNC_BEG
scanin_start  out  1  one-clk strobe, coincides with cend at hcount==SCANIN_BEG
hint_start  out  1  one-clk strobe, coincides with cend at hcount==HINT_BEG
hpix  out  1  pixel output window
pix_x  out  CW  pixel column index, valid while hpix=1
hcount  out  CW  raw line position

Behaviour:
- rst (takes priority over all other inputs):
  - hcount=0, mode_cur=mode, pix_x=0.
  - All level outputs and strobes = 0.
- Counter (on cend only):
  - init=1 or hcount==HPERIOD-1 -> hcount<=0; otherwise hcount+1.
  - Without cend, hcount holds.
- Mode latch: on the same cend edge that loads hcount<=0 (wrap or init), mode_cur<=mode. A mode change at any other time has no effect until the next wrap.
- Level outputs (on cend, comparisons use the pre-edge hcount, result visible the next clk):
  - hblank: set at hcount==0, cleared at HBLNK_END.
  - hsync: set at HSYNC_BEG, cleared at HSYNC_END.
  - Set and clear never coincide, because parameters must satisfy 0<HSYNC_BEG<HSYNC_END<HBLNK_END<HPERIOD.
- hpix (on cend):
  - Set when hcount==HPIX_BEG[mode_cur], unless BEG==END; then set pix_x<=0.
  - While hpix=1, pix_x increments.
  - Cleared at hcount==HPIX_END[mode_cur].
  - Width is exactly END-BEG cend ticks, so pix_x runs 0..END-BEG-1.
  - HPIX_END must be < HPERIOD.
- init with cend while hpix=1 forces hpix<=0 and pix_x<=0 on that edge (no truncated window carried into the new phase). hblank/hsync follow the normal rules from hcount=0.
- Strobes (line_start, hsync_start, scanin_start, hint_start):
  - Registered from pre_cend && hcount==X; forced to 0 on any clk without pre_cend.
  - Each is exactly one clk wide and coincides with the following cend.
  - If pre_cend is asserted while init is pending, the strobe still follows the pre-edge hcount.
- pix_x holds its last value outside the window.
- Bit-exact compatibility: with mode held at 0 or 1, all outputs must match the legacy Pentagon/ATM generator cycle-for-cycle.

Decomposition:
- Package video_timing_pkg:
  - default timing constants above;
  - mode encoding localparams MODE_PENT=0, MODE_ATM=1, MODE_W352=2, MODE_BORDER=3;
  - CW default.
- One sub-module: video_hwindow, a set/reset window flop with enable (inputs pos, beg, end, en; output win), instanced for hblank, hsync and hpix.
- Strobe logic, counter and mode latch stay in the top level.

Test Plan:
- Reset, then free-run with cend every 2 clk and mode=0:
  - hcount period is 448 cend;
  - hsync high for hcount 11..43, i.e. 33 ticks;
  - hblank high for hcount 1..88;
  - hpix high for 256 ticks;
  - pix_x ends at 255.
- mode=1 held: hpix spans 320 ticks starting after hcount==108; line_start coincides with the cend at hcount==88; hint_start coincides with the cend at hcount==443.
- Switch mode 0->1 at hcount==200: current line keeps the 256-pixel window; mode_cur changes on the edge where hcount wraps 447->0; the next line has 320 pixels.
- mode=3: hpix stays 0 all line; pix_x never changes; hblank/hsync are unchanged.
- init pulsed with cend at hcount==250 in mode 0: next hcount=0, hpix=0, pix_x=0; the following line is a full 448 ticks with a 256-pixel window.
- rst asserted at hcount==300 mid-window: all outputs are 0 the next clk; after release, counting restarts from 0 and mode_cur equals the mode input.
